ssd_readback: RTL

- Reader end of the multiplexed seven-segment display interface.
- Samples the active-low anode selects and segment pins driven toward the board display, and waits for each pattern to be stable.
- Decodes each stable segment pattern back to a BCD digit and keeps a per-digit captured value with valid, blank and error status.
- Used as an on-chip self-check of the display path and as a debug readback of displayed values.

---
 rtl/ssd_readback.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ssd_readback.sv
// Seven-segment readback: waits for a stable anode/segment pattern,
// decodes it and keeps per-digit captured values with status flags.
module ssd_readback #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              ssd_pins,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    update,
  output logic                    err_pattern,
  output logic                    err_anode
);

  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic [SW-1:0]           samp;
  logic [SW-1:0]           din;
  logic [CNT_W-1:0]        cnt;
  logic                    done;
  logic                    fire;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              pins;
  logic                    onehot;
  logic                    multi;
  logic                    is_num;
  logic                    is_blank;
  logic [3:0]              val;
  logic [4*NUM_DIGITS-1:0] nxt_d;
  logic [NUM_DIGITS-1:0]   nxt_v;
  logic [NUM_DIGITS-1:0]   nxt_b;
  logic                    changed;
  logic                    set_p;
  logic                    set_a;

  assign din  = {an_n, ssd_pins};
  assign an   = ~samp[SW-1:7];
  assign pins = samp[6:0];
  assign fire = (cnt == LAST) && !done;

  assign onehot = (an != '0) && ((an & (an - ONE)) == '0);
  assign multi  = (an != '0) && !onehot;

  always_comb begin
    is_num   = 1'b1;
    is_blank = 1'b0;
    val      = 4'd0;
    case (pins)
      7'h40: val = 4'd0;
      7'h79: val = 4'd1;
      7'h24: val = 4'd2;
      7'h30: val = 4'd3;
      7'h19: val = 4'd4;
      7'h12: val = 4'd5;
      7'h02: val = 4'd6;
      7'h78: val = 4'd7;
      7'h00: val = 4'd8;
      7'h10: val = 4'd9;
      7'h7f: begin
        is_num   = 1'b0;
        is_blank = 1'b1;
      end
      default: is_num = 1'b0;
    endcase
  end

  always_comb begin
    nxt_d = digits;
    nxt_v = digit_valid;
    nxt_b = blank;
    if (fire && onehot) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (an[k]) begin
          if (is_num) nxt_d[4*k +: 4] = val;
          nxt_v[k] = is_num;
          nxt_b[k] = is_blank;
        end
      end
    end
  end

  assign changed = (nxt_d != digits) ||
                   (nxt_v != digit_valid) ||
                   (nxt_b != blank);
  assign set_p = fire && onehot && !is_num && !is_blank;
  assign set_a = fire && multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp        <= '1;
      cnt         <= '0;
      done        <= 1'b1;
      digits      <= '0;
      digit_valid <= '0;
      blank       <= '0;
      update      <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      // a fresh run on the commit edge must still clear done
      if (fire) done <= 1'b1;
      if (din == samp) begin
        if (cnt != LAST) cnt <= cnt + 1'b1;
      end else begin
        samp <= din;
        cnt  <= '0;
        done <= 1'b0;
      end
      digits      <= nxt_d;
      digit_valid <= nxt_v;
      blank       <= nxt_b;
      update      <= fire && changed;
      err_pattern <= set_p | (err_pattern & ~err_clr);
      err_anode   <= set_a | (err_anode & ~err_clr);
    end
  end

endmodule
